btn_reboot_ctrl: RTL

Conditions the raw OrangeCrab user button and decides when to reboot into the bootloader. It synchronises and debounces `usr_btn`, then classifies each press as short or long. A long press drives the active-low `rsn_n` reboot line low for a fixed hold time while the button is still held, so the bootloader sees the button pressed at restart. It sits between the `usr_btn` pad and the `rsn_n` pad, upstream of any user logic consuming button events.

---
 rtl/btn_reboot_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/btn_reboot_ctrl.sv
// btn_reboot_ctrl: synchronises and debounces the OrangeCrab user button and
// classifies presses. A short press produces a one-cycle pulse. A long press
// pulls rsn_n low for a fixed time while the button is still held, so the
// bootloader sees the button pressed when it restarts.
module btn_reboot_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 480000,
    parameter int LONG_PRESS_CYCLES = 96000000,
    parameter int RESET_HOLD_CYCLES = 4800
) (
    input  logic clk48,
    input  logic rst,
    input  logic usr_btn,
    output logic btn_pressed,
    output logic short_press,
    output logic reboot_pending,
    output logic rsn_n
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = (LONG_PRESS_CYCLES > RESET_HOLD_CYCLES) ?
                              LONG_PRESS_CYCLES : RESET_HOLD_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {IDLE, PRESSED, REBOOT, LOCKOUT} state_t;

    logic              sync1_q, btn_sync_q;
    logic              level_q, level_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              short_q, short_d;
    logic              pend_q, pend_d;
    logic              rsn_n_q, rsn_n_d;

    // Two-flop synchroniser for the asynchronous pad; resets to "released"
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            btn_sync_q <= 1'b1;
        end else begin
            sync1_q    <= usr_btn;
            btn_sync_q <= sync1_q;
        end
    end

    // Debounce: count consecutive disagreeing samples, toggle on the Nth one
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        if (~btn_sync_q != level_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1))
                level_d = ~level_q;
            else
                db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // Debounced level and its stability counter
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            level_q  <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // FSM state and shared hold counter (press duration, then reboot pulse)
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next state. The long-press threshold fires on the edge where the hold
    // counter would step to LONG_PRESS_CYCLES-1, so a release already visible
    // on that edge still wins and yields a short press.
    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        case (state_q)
            IDLE: begin
                // level is always low on entry to IDLE, so high here is a rise
                if (level_q) state_d = PRESSED;
            end
            PRESSED: begin
                if (!level_q)
                    state_d = IDLE;
                else if (hold_q == HOLD_W'(LONG_PRESS_CYCLES - 2))
                    state_d = REBOOT;
                else
                    hold_d = hold_q + 1'b1;
            end
            REBOOT: begin
                if (hold_q == HOLD_W'(RESET_HOLD_CYCLES - 1))
                    state_d = LOCKOUT;
                else
                    hold_d = hold_q + 1'b1;
            end
            LOCKOUT: begin
                if (!level_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode, computed from the transition so the registers line up
    // with the state they describe
    always_comb begin
        short_d = (state_q == PRESSED) && !level_q;
        rsn_n_d = (state_d != REBOOT);
        pend_d  = (state_d == REBOOT) || (state_d == LOCKOUT);
    end

    // Registered outputs; async reset releases rsn_n immediately
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            short_q <= 1'b0;
            pend_q  <= 1'b0;
            rsn_n_q <= 1'b1;
        end else begin
            short_q <= short_d;
            pend_q  <= pend_d;
            rsn_n_q <= rsn_n_d;
        end
    end

    assign btn_pressed    = level_q;
    assign short_press    = short_q;
    assign reboot_pending = pend_q;
    assign rsn_n          = rsn_n_q;

endmodule
